iomem_bellek_denetleyici: RTL

//  Memory-side responder for the core's iomem bus. Sits between islemci (iomem_valid/ready/wstrb/addr/wdata/rdata)
//  and a word-wide single-port memory (memory_model-style cmd/wr_en/addr/data port).

---
 rtl/bellek_pkg.sv | 35 +++
 rtl/bellek_bayt_birlestirici.sv | 19 +
 rtl/iomem_bellek_denetleyici.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bellek_pkg.sv
// Shared definitions for the iomem memory-side responder: FSM encoding,
// default error pattern, full-word strobe and dispatch helpers.
package bellek_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LAT  = 3'd1,
        ST_RD   = 3'd2,
        ST_RDW  = 3'd3,
        ST_WR   = 3'd4,
        ST_RESP = 3'd5
    } durum_t;

    localparam logic [31:0] ERR_DATA_VARSAYILAN = 32'hDEAD_BEEF;
    localparam logic [3:0]  WSTRB_FULL          = 4'hF;

    // True when the byte address falls inside [base, base+bytes).
    function automatic logic aralikta(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] bytes);
        return (addr >= base) && ((addr - base) < bytes);
    endfunction

    // First memory-facing state once any wait states have elapsed.
    // Partial writes start with a read so the untouched bytes can be merged.
    function automatic durum_t dispatch(input logic       in_range,
                                        input logic [3:0] wstrb);
        if (!in_range)
            return ST_RESP;
        if (wstrb == WSTRB_FULL)
            return ST_WR;
        return ST_RD;
    endfunction

endpackage

// File: rtl/bellek_bayt_birlestirici.sv
// Combinational byte merge: each byte lane takes the new value when its
// strobe is set, otherwise keeps the old word's byte.
module bellek_bayt_birlestirici (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  wstrb,
    output logic [31:0] merged
);

    // Per-lane select between the old and new byte.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i])
                merged[8*i +: 8] = new_word[8*i +: 8];
        end
    end

endmodule

// File: rtl/iomem_bellek_denetleyici.sv
// Memory-side responder for the iomem bus. One request at a time, optional
// wait states, read-modify-write for partial strobes, error response for
// addresses outside the served window.
module iomem_bellek_denetleyici
    import bellek_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter logic [31:0] MEM_BYTES   = 32'h0004_0000,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_VARSAYILAN
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        iomem_valid_i,
    output logic        iomem_ready_o,
    input  logic [3:0]  iomem_wstrb_i,
    input  logic [31:0] iomem_addr_i,
    input  logic [31:0] iomem_wdata_i,
    output logic [31:0] iomem_rdata_o,
    output logic        mem_cmd_valid_o,
    output logic [31:0] mem_cmd_addr_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_wr_data_o,
    input  logic [31:0] mem_rd_data_i,
    output logic        err_o,
    output logic [7:0]  err_count_o
);

    // Counter value on the last wait cycle; unused when there are no wait states.
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    durum_t      state_q;
    durum_t      state_d;
    logic [29:0] word_addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        in_range_q;
    logic [31:0] rdata_q;
    logic [3:0]  wait_cnt_q;
    logic [7:0]  err_cnt_q;
    logic        in_range_d;
    logic [31:0] merged;

    assign in_range_d = aralikta(iomem_addr_i, BASE_ADDR, MEM_BYTES);

    bellek_bayt_birlestirici u_birlestirici (
        .old_word (rdata_q),
        .new_word (wdata_q),
        .wstrb    (wstrb_q),
        .merged   (merged)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Capture the request once, in IDLE; later changes on the bus are ignored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_addr_q <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            in_range_q  <= 1'b0;
        end else if (state_q == ST_IDLE && iomem_valid_i) begin
            word_addr_q <= iomem_addr_i[31:2];
            wdata_q     <= iomem_wdata_i;
            wstrb_q     <= iomem_wstrb_i;
            in_range_q  <= in_range_d;
        end
    end

    // Wait-state counter: counts only while in LAT, cleared elsewhere.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            wait_cnt_q <= '0;
        else if (state_q == ST_LAT)
            wait_cnt_q <= wait_cnt_q + 4'd1;
        else
            wait_cnt_q <= '0;
    end

    // Memory read data arrives the cycle after the read command.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            rdata_q <= '0;
        else if (state_q == ST_RDW)
            rdata_q <= mem_rd_data_i;
    end

    // Saturating count of out-of-range responses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            err_cnt_q <= '0;
        else if (state_q == ST_RESP && !in_range_q && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (iomem_valid_i) begin
                    if (WAIT_CYCLES > 0)
                        state_d = ST_LAT;
                    else
                        state_d = dispatch(in_range_d, iomem_wstrb_i);
                end
            end
            ST_LAT: begin
                if (wait_cnt_q == WAIT_LAST)
                    state_d = dispatch(in_range_q, wstrb_q);
            end
            ST_RD:   state_d = ST_RDW;
            ST_RDW:  state_d = (wstrb_q == 4'h0) ? ST_RESP : ST_WR;
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state; everything idles at zero.
    always_comb begin
        iomem_ready_o   = 1'b0;
        iomem_rdata_o   = '0;
        mem_cmd_valid_o = 1'b0;
        mem_cmd_addr_o  = '0;
        mem_wr_en_o     = 1'b0;
        mem_wr_data_o   = '0;
        err_o           = 1'b0;
        case (state_q)
            ST_RD: begin
                mem_cmd_valid_o = 1'b1;
                mem_cmd_addr_o  = {word_addr_q, 2'b00};
            end
            ST_WR: begin
                mem_cmd_valid_o = 1'b1;
                mem_cmd_addr_o  = {word_addr_q, 2'b00};
                mem_wr_en_o     = 1'b1;
                // A full strobe selects every byte of wdata, so the merge covers both cases.
                mem_wr_data_o   = merged;
            end
            ST_RESP: begin
                iomem_ready_o = 1'b1;
                err_o         = !in_range_q;
                if (wstrb_q == 4'h0)
                    iomem_rdata_o = in_range_q ? rdata_q : ERR_DATA;
            end
            default: ;
        endcase
    end

    assign err_count_o = err_cnt_q;

endmodule
